regfile_writeback_arbiter: RTL
==============================

Name: regfile_writeback_arbiter

Overview:
- Producer side of the register-file write port. Collects results from the ALU path and the memory/load path, arbitrates between them, and drives one registered write per cycle into the register file (write_en/write_addr/write_data).
- Keeps a pending-destination scoreboard that the issue stage uses for read-after-write hazard stalls.
- Sits between the execute/memory stages and the register file.

Parameters:
- WORDSIZE, 64, data width in bits.
- SIZE, 32, number of architectural registers; register 0 is hardwired zero.
- MAX_STALL, 4, number of consecutive cycles the ALU path may be blocked before it gets forced priority (range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU result available.
- alu_ready  output  1  ALU result accepted this cycle.
- alu_rd  input  5  ALU destination register.
- alu_data  input  WORDSIZE  ALU result.
- mem_valid  input  1  load result available.
- mem_ready  output  1  load result accepted this cycle.
- mem_rd  input  5  load destination register.
- mem_data  input  WORDSIZE  load result.
- issue_valid  input  1  an instruction with a destination is issued this cycle.
- issue_rd  input  5  destination of the issued instruction.
- write_en  output  1  register file write enable.
- write_addr  output  5  register file write address.
- write_data  output  WORDSIZE  register file write data.
- pending  output  SIZE  bit i=1 means register i has an outstanding write.

Behaviour:
- Reset (async, active-high): write_en=0, write_addr=0, write_data=0, pending=0, stall counter=0.
  - alu_ready and mem_ready are 0 while reset is asserted.
  - Reset asserted mid-transfer discards any result not yet committed.
- Handshake:
  - A transfer occurs on a rising edge when valid&&ready.
  - ready is combinational from the valid inputs and the stall counter.
  - At most one of alu_ready/mem_ready is 1 per cycle.
  - ready may be 1 with valid=0; such a cycle is not a transfer.
- Arbitration, default: mem has priority.
  - If mem_valid, then mem_ready=1 and alu_ready=0.
  - Otherwise alu_ready=alu_valid.
- Starvation counter:
  - Increments each cycle in which alu_valid=1 and alu_ready=0, saturating at MAX_STALL.
  - Clears to 0 on any ALU transfer, or on any cycle with alu_valid=0.
  - When the counter equals MAX_STALL, the ALU has priority: alu_ready=alu_valid, mem_ready=0 if alu_valid.
- Write port timing:
  - Registered, 1-cycle latency. A transfer at edge N produces write_en=1, write_addr=rd, write_data=data during cycle N+1.
  - The register file commits at edge N+1.
  - With no transfer, write_en=0 next cycle; write_addr/write_data hold their previous values.
- Register 0:
  - Transfers with rd=0 are accepted (ready asserts normally) but produce write_en=0.
  - Register 0 is never marked pending.
- Scoreboard:
  - issue_valid with issue_rd≠0 sets pending[issue_rd] at the edge.
  - A write commit (write_en=1 at an edge) clears pending[write_addr] at that edge.
  - If the same register is set and cleared at the same edge, set wins: the new producer is still outstanding.
  - Setting an already-pending bit is legal; the bit stays 1.
  - Clearing a non-pending bit has no effect.
- pending is a registered output, updated on the clock edge only.
- No data forwarding in this block. The consumer reads the register file after the commit.

Test Plan:
- Reset then single ALU write: alu_valid=1, alu_rd=5, alu_data=0x1234 for 1 cycle → alu_ready=1 that cycle; next cycle write_en=1, write_addr=5, write_data=0x1234; following cycle write_en=0.
- Simultaneous results: mem_valid=1 (rd=3, 0xAA) and alu_valid=1 (rd=4, 0xBB) in the same cycle → mem wins first (write x3=0xAA), ALU accepted the next cycle (write x4=0xBB). Check writes on consecutive cycles and no lost transfer.
- Starvation: mem_valid held 1 continuously, alu_valid=1, MAX_STALL=4 → alu_ready=0 for 4 cycles, then alu_ready=1 and mem_ready=0 for exactly 1 cycle; counter returns to 0; mem resumes.
- Register 0: issue_valid with issue_rd=0, then ALU transfer with rd=0, data=0xFFFF → pending stays all-zero, write_en stays 0, alu_ready=1.
- Scoreboard set/clear collision: issue rd=7 → pending[7]=1; ALU write rd=7 commits at the same edge as a new issue rd=7 → pending[7] remains 1; a later commit of x7 with no issue → pending[7]=0.
- Async reset mid-operation: assert reset between clock edges during an accepted ALU transfer → write_en=0 and pending=0 immediately, without waiting for a clock edge; no write of the discarded result after reset is released.

Source files
------------

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port arbiter: merges ALU and load results into one registered
// write per cycle and tracks outstanding destinations for issue-stage hazard checks.
module regfile_writeback_arbiter #(
    parameter int unsigned WORDSIZE  = 64,
    parameter int unsigned SIZE      = 32,
    parameter int unsigned MAX_STALL = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [4:0]          alu_rd,
    input  logic [WORDSIZE-1:0] alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [4:0]          mem_rd,
    input  logic [WORDSIZE-1:0] mem_data,
    input  logic                issue_valid,
    input  logic [4:0]          issue_rd,
    output logic                write_en,
    output logic [4:0]          write_addr,
    output logic [WORDSIZE-1:0] write_data,
    output logic [SIZE-1:0]     pending
);

    localparam int unsigned RD_W  = 5;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(MAX_STALL);

    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                we_q, we_d;
    logic [RD_W-1:0]     wa_q, wa_d;
    logic [WORDSIZE-1:0] wd_q, wd_d;
    logic [SIZE-1:0]     pend_q, pend_d;

    logic alu_force;
    logic alu_xfer;
    logic mem_xfer;

    // Memory path wins by default; a starved ALU takes over once the counter saturates.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        alu_force = (stall_q == STALL_MAX);
        if (!reset) begin
            if (alu_force && alu_valid) begin
                alu_ready = 1'b1;
            end else if (mem_valid) begin
                mem_ready = 1'b1;
            end else begin
                alu_ready = alu_valid;
            end
        end
        alu_xfer = alu_valid && alu_ready;
        mem_xfer = mem_valid && mem_ready;
    end

    always_comb begin
        stall_d = stall_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        pend_d  = pend_q;

        if (alu_valid && !alu_ready) begin
            if (stall_q != STALL_MAX) begin
                stall_d = stall_q + CNT_W'(1);
            end
        end else begin
            stall_d = '0;
        end

        if (mem_xfer) begin
            we_d = (mem_rd != '0);
            wa_d = mem_rd;
            wd_d = mem_data;
        end else if (alu_xfer) begin
            we_d = (alu_rd != '0);
            wa_d = alu_rd;
            wd_d = alu_data;
        end

        // Clear on commit first so a same-edge issue to that register keeps it pending.
        if (we_q) begin
            pend_d[wa_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pend_d[issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            pend_q  <= '0;
        end else begin
            stall_q <= stall_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            pend_q  <= pend_d;
        end
    end

    assign write_en   = we_q;
    assign write_addr = wa_q;
    assign write_data = wd_q;
    assign pending    = pend_q;

endmodule
